bidir_io_port: RTL and testbench

//  Parametrised WIDTH-bit bidirectional I/O port for the KCPSM3 peripheral set.

---
 rtl/bidir_io_port.sv | 138 +++++++++++++
 tb/tb_bidir_io_port.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bidir_io_port.sv
// WIDTH-bit bidirectional I/O port: output data register, turnaround-guarded tri-state mask, pad synchroniser.
// Optional edge interrupts are built when BIDIR_IO_PORT_EDGE_IRQ_EN is defined.
module bidir_io_port #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TURN_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data_wr,
  input  logic [WIDTH-1:0] data_in,
  input  logic             tri_wr,
  input  logic [WIDTH-1:0] tri_in,
  output logic [WIDTH-1:0] pad_o,
  output logic [WIDTH-1:0] pad_t,
  input  logic [WIDTH-1:0] pad_i,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  input  logic [WIDTH-1:0] irq_clr,
  output logic [WIDTH-1:0] irq_flags,
  output logic             irq
);

  typedef enum logic {
    IDLE,
    TURN
  } state_t;

  localparam logic [3:0] TURN_LOAD = 4'(TURN_CYCLES);

  state_t           state;
  logic [3:0]       turn_cnt;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] enabling;
  logic [WIDTH-1:0] released_t;

  // Bits asked to go from high-Z to driven need the dead time; releases never wait.
  assign enabling   = pad_t & ~tri_in;
  assign released_t = pad_t | tri_in;

  // NOTE: registers are assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      pad_o <= '0;
    end else if (data_wr) begin
      pad_o <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      turn_cnt <= '0;
      pending  <= '0;
      pad_t    <= '1;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (tri_wr) begin
            if (enabling == '0 || TURN_CYCLES == 0) begin
              pad_t <= tri_in;
            end else begin
              pad_t    <= released_t;
              pending  <= tri_in;
              turn_cnt <= TURN_LOAD;
              busy     <= 1'b1;
              state    <= TURN;
            end
          end
        end
        TURN: begin
          if (tri_wr) begin
            // A new request restarts the full dead time; bits already driving stay driven.
            pad_t    <= released_t;
            pending  <= tri_in;
            turn_cnt <= TURN_LOAD;
          end else if (turn_cnt == 4'd1) begin
            pad_t    <= pending;
            turn_cnt <= '0;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            turn_cnt <= turn_cnt - 4'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];

  // NOTE: synchroniser flops are reset explicitly so readback is defined right after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      sync_q[0] <= pad_i;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  assign rd_data = sync_q[SYNC_STAGES-1];

`ifdef BIDIR_IO_PORT_EDGE_IRQ_EN
  logic [WIDTH-1:0] rd_prev;
  logic [WIDTH-1:0] flags_next;

  // Set wins over a simultaneous clear.
  assign flags_next = (irq_flags & ~irq_clr) | (rd_data & ~rd_prev);

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_prev   <= '0;
      irq_flags <= '0;
      irq       <= 1'b0;
    end else begin
      rd_prev   <= rd_data;
      irq_flags <= flags_next;
      irq       <= |flags_next;
    end
  end
`else
  logic unused_irq_clr;

  assign unused_irq_clr = ^irq_clr;
  assign irq_flags      = '0;
  assign irq            = 1'b0;
`endif

endmodule

// File: tb/tb_bidir_io_port.sv
// Scoreboard bench for bidir_io_port: stimulus queues timed expectations, a negedge monitor checks them.
module tb_bidir_io_port;

  localparam int W = 8;

`ifdef BIDIR_IO_PORT_EDGE_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         data_wr = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         tri_wr = 1'b0;
  logic [W-1:0] tri_in = '0;
  logic [W-1:0] pad_o;
  logic [W-1:0] pad_t;
  logic [W-1:0] pad_i = '0;
  logic [W-1:0] rd_data;
  logic         busy;
  logic [W-1:0] irq_clr = '0;
  logic [W-1:0] irq_flags;
  logic         irq;

  bidir_io_port #(
    .WIDTH      (W),
    .SYNC_STAGES(2),
    .TURN_CYCLES(2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .data_wr  (data_wr),
    .data_in  (data_in),
    .tri_wr   (tri_wr),
    .tri_in   (tri_in),
    .pad_o    (pad_o),
    .pad_t    (pad_t),
    .pad_i    (pad_i),
    .rd_data  (rd_data),
    .busy     (busy),
    .irq_clr  (irq_clr),
    .irq_flags(irq_flags),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  typedef enum int {F_PAD_O, F_PAD_T, F_RD, F_BUSY, F_FLAGS, F_IRQ} field_e;

  typedef struct {
    string  name;
    int     at_cyc;
    field_e fld;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];
  exp_t held[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void exp_at(string n, int k, field_e f, logic [7:0] v);
    exp_t e;
    e.name = n;
    e.at_cyc = cyc + k;
    e.fld = f;
    e.val = v;
    sb.push_back(e);
  endfunction

  task automatic check(exp_t e);
    logic [7:0] act;
    case (e.fld)
      F_PAD_O: act = pad_o;
      F_PAD_T: act = pad_t;
      F_RD:    act = rd_data;
      F_BUSY:  act = {7'b0, busy};
      F_FLAGS: act = irq_flags;
      default: act = {7'b0, irq};
    endcase
    n_tests++;
    if (act !== e.val) begin
      n_fail++;
      $display("FAIL %s (%s) at cycle %0d: got %h, expected %h", e.name, e.fld.name(), cyc, act, e.val);
    end
  endtask

  // Monitor: checks every expectation that has come due, keeps the rest.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      held.delete();
      foreach (sb[i]) begin
        if (sb[i].at_cyc <= cyc) check(sb[i]);
        else held.push_back(sb[i]);
      end
      sb = held;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
    data_wr = 1'b0;
    tri_wr  = 1'b0;
    irq_clr = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    step();
    reset = 1'b0;
    exp_at("reset", 1, F_PAD_T, 8'hFF);
    exp_at("reset", 1, F_PAD_O, 8'h00);
    exp_at("reset", 1, F_BUSY, 8'h00);
    exp_at("reset", 1, F_RD, 8'h00);
    exp_at("reset", 1, F_FLAGS, 8'h00);
    exp_at("reset", 1, F_IRQ, 8'h00);

    step();
    data_wr = 1'b1; data_in = 8'hA5;
    exp_at("data_wr", 1, F_PAD_O, 8'hA5);
    exp_at("data_wr", 1, F_PAD_T, 8'hFF);
    exp_at("data_wr", 1, F_BUSY, 8'h00);

    step();
    tri_wr = 1'b1; tri_in = 8'hF0;
    exp_at("turn_c1", 1, F_BUSY, 8'h01);
    exp_at("turn_c1", 1, F_PAD_T, 8'hFF);
    exp_at("turn_c2", 2, F_BUSY, 8'h01);
    exp_at("turn_c2", 2, F_PAD_T, 8'hFF);
    exp_at("turn_done", 3, F_BUSY, 8'h00);
    exp_at("turn_done", 3, F_PAD_T, 8'hF0);

    repeat (3) step();
    tri_wr = 1'b1; tri_in = 8'hFF;
    exp_at("release", 1, F_PAD_T, 8'hFF);
    exp_at("release", 1, F_BUSY, 8'h00);
    exp_at("release", 1, F_PAD_O, 8'hA5);

    step();
    tri_wr = 1'b1; tri_in = 8'h0F;
    exp_at("retrig_first", 1, F_BUSY, 8'h01);
    exp_at("retrig_first", 1, F_PAD_T, 8'hFF);
    step();
    tri_wr = 1'b1; tri_in = 8'h00;
    exp_at("retrig_c1", 1, F_PAD_T, 8'hFF);
    exp_at("retrig_c1", 1, F_BUSY, 8'h01);
    exp_at("retrig_c2", 2, F_PAD_T, 8'hFF);
    exp_at("retrig_c2", 2, F_BUSY, 8'h01);
    exp_at("retrig_done", 3, F_PAD_T, 8'h00);
    exp_at("retrig_done", 3, F_BUSY, 8'h00);

    repeat (3) step();
    tri_wr = 1'b1; tri_in = 8'hFF;
    exp_at("release_all", 1, F_PAD_T, 8'hFF);

    step();
    tri_wr = 1'b1; tri_in = 8'h0F;
    exp_at("midturn_busy", 1, F_BUSY, 8'h01);
    step();
    reset = 1'b1;
    exp_at("midturn_reset", 1, F_PAD_T, 8'hFF);
    exp_at("midturn_reset", 1, F_BUSY, 8'h00);
    exp_at("midturn_reset", 1, F_PAD_O, 8'h00);
    step();
    reset = 1'b0;
    exp_at("post_reset_c1", 1, F_PAD_T, 8'hFF);
    exp_at("post_reset_c1", 1, F_BUSY, 8'h00);
    exp_at("post_reset_c2", 2, F_PAD_T, 8'hFF);
    exp_at("post_reset_c3", 3, F_PAD_T, 8'hFF);
    exp_at("post_reset_c3", 3, F_BUSY, 8'h00);

    repeat (3) step();
    tri_wr = 1'b1; tri_in = 8'hF0;
    data_wr = 1'b1; data_in = 8'h5A;
    exp_at("both_wr", 1, F_PAD_O, 8'h5A);
    exp_at("both_wr", 1, F_PAD_T, 8'hFF);
    exp_at("both_wr", 1, F_BUSY, 8'h01);
    exp_at("both_wr_done", 3, F_PAD_T, 8'hF0);

    repeat (3) step();
    tri_wr = 1'b1; tri_in = 8'h00;
    exp_at("keep_drive_c1", 1, F_PAD_T, 8'hF0);
    exp_at("keep_drive_c1", 1, F_BUSY, 8'h01);
    exp_at("keep_drive_c2", 2, F_PAD_T, 8'hF0);
    exp_at("keep_drive_done", 3, F_PAD_T, 8'h00);
    exp_at("keep_drive_done", 3, F_BUSY, 8'h00);

    repeat (3) step();
    tri_wr = 1'b1; tri_in = 8'h0F;
    exp_at("part_release", 1, F_PAD_T, 8'h0F);
    exp_at("part_release", 1, F_BUSY, 8'h00);

    step();
    pad_i = 8'h3C;
    exp_at("sync_early", 1, F_RD, 8'h00);
    exp_at("sync_arrive", 2, F_RD, 8'h3C);

    repeat (3) step();
    pad_i = 8'hC3;
    exp_at("sync2_early", 1, F_RD, 8'h3C);
    exp_at("sync2_arrive", 2, F_RD, 8'hC3);
    exp_at("flags_accum", 3, F_FLAGS, IRQ_ON ? 8'hFF : 8'h00);
    exp_at("flags_accum", 3, F_IRQ, {7'b0, IRQ_ON});

    repeat (3) step();
    irq_clr = 8'hFF; pad_i = 8'h00;
    exp_at("clear_all", 1, F_FLAGS, 8'h00);
    exp_at("clear_all", 1, F_IRQ, 8'h00);

    repeat (3) step();
    pad_i = 8'h02;
    exp_at("bit1_rd", 2, F_RD, 8'h02);
    exp_at("bit1_pre", 2, F_FLAGS, 8'h00);
    exp_at("bit1_pre", 2, F_IRQ, 8'h00);
    exp_at("bit1_flag", 3, F_FLAGS, IRQ_ON ? 8'h02 : 8'h00);
    exp_at("bit1_flag", 3, F_IRQ, {7'b0, IRQ_ON});

    repeat (3) step();
    irq_clr = 8'h02; pad_i = 8'h00;
    exp_at("bit1_clear", 1, F_FLAGS, 8'h00);
    exp_at("bit1_clear", 1, F_IRQ, 8'h00);

    repeat (3) step();
    pad_i = 8'h02;
    exp_at("coinc_pre", 2, F_FLAGS, 8'h00);
    step();
    step();
    irq_clr = 8'h02;
    exp_at("set_wins", 1, F_FLAGS, IRQ_ON ? 8'h02 : 8'h00);
    exp_at("set_wins", 1, F_IRQ, {7'b0, IRQ_ON});

    step();
    irq_clr = 8'h02;
    exp_at("final_clear", 1, F_FLAGS, 8'h00);
    exp_at("final_clear", 1, F_IRQ, 8'h00);

    for (int i = 0; i < 20 && sb.size() != 0; i++) step();
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
